booth_seq_controller: RTL and testbench

//  Sequencer for the 8x8 signed Booth multiplier. Drives the 17-bit variable-shift

---
 rtl/booth_seq_controller.sv | 100 ++++++++++
 tb/tb_booth_seq_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_controller.sv
// Sequencer for an external 17-bit {A,Q,Q-1} shift register implementing 8x8 signed Booth
// multiplication; runs of equal multiplier bits are skipped with one multi-bit shift.
module booth_seq_controller #(
    parameter int MAX_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    input  logic [16:0] reg_q,
    output logic        reg_load,
    output logic        reg_shift,
    output logic [4:0]  reg_amount,
    output logic [16:0] reg_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [7:0]  m_q;
    logic [3:0]  rem_q;
    logic [4:0]  amt_q;
    logic [15:0] prod_q;
    logic [3:0]  amt_d;
    logic        pair_add;
    logic        pair_sub;

    assign pair_sub = reg_q[1] & ~reg_q[0];
    assign pair_add = ~reg_q[1] & reg_q[0];

    // Length of the run of bits equal to Q[0] (now at reg_q[1]), bounded by what is left.
    always_comb begin
        amt_d = rem_q;
        for (int s = 7; s >= 1; s--) begin
            if (s < int'(rem_q) && reg_q[s+1] != reg_q[1]) amt_d = 4'(s);
        end
        if (amt_d > 4'(MAX_SHIFT)) amt_d = 4'(MAX_SHIFT);
    end

    always_comb begin
        reg_data = reg_q;
        case (state_q)
            LOAD: reg_data = {8'h00, multiplier, 1'b0};
            EVAL: begin
                if (pair_sub) reg_data = {reg_q[16:9] - m_q, reg_q[8:0]};
                if (pair_add) reg_data = {reg_q[16:9] + m_q, reg_q[8:0]};
            end
            default: reg_data = reg_q;
        endcase
    end

    assign reg_load   = (state_q == LOAD) || (state_q == EVAL && (pair_add || pair_sub));
    assign reg_shift  = (state_q == SHIFT);
    assign reg_amount = amt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = done && (m_q == 8'h80);
    // Final register contents appear in the DONE cycle itself, then are held.
    assign product    = done ? reg_q[16:1] : prod_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= 8'h00;
            rem_q   <= 4'd0;
            amt_q   <= 5'd0;
            prod_q  <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= multiplicand;
                        rem_q   <= 4'd8;
                        state_q <= LOAD;
                    end
                end
                LOAD: state_q <= EVAL;
                EVAL: begin
                    amt_q   <= {1'b0, amt_d};
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    rem_q   <= rem_q - amt_q[3:0];
                    state_q <= (rem_q == amt_q[3:0]) ? DONE : EVAL;
                end
                DONE: begin
                    prod_q  <= reg_q[16:1];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_controller.sv
// Bench for booth_seq_controller: two instances (MAX_SHIFT 8 and 4) share stimulus, each
// paired with a behavioural shift register; results checked against run-length/product model.
module tb_booth_seq_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [16:0] rq  [2];
    logic        ld  [2];
    logic        sh  [2];
    logic [4:0]  am  [2];
    logic [16:0] rd  [2];
    logic        bsy [2];
    logic        dn  [2];
    logic [15:0] pr  [2];
    logic        er  [2];
    logic [4:0]  lat [2];

    int errors = 0;
    int checks = 0;
    int exp_amt [2][16];
    int exp_n [2];
    int exp_loads [2];

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] prod;
        logic        err;
        int          cyc;
    } vec_t;
    vec_t tbl [6];

    booth_seq_controller u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier), .reg_q(rq[0]),
        .reg_load(ld[0]), .reg_shift(sh[0]), .reg_amount(am[0]), .reg_data(rd[0]),
        .busy(bsy[0]), .done(dn[0]), .product(pr[0]), .err(er[0])
    );

    booth_seq_controller #(.MAX_SHIFT(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier), .reg_q(rq[1]),
        .reg_load(ld[1]), .reg_shift(sh[1]), .reg_amount(am[1]), .reg_data(rd[1]),
        .busy(bsy[1]), .done(dn[1]), .product(pr[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register: amount captured on the falling edge, load/shift on the rising edge.
    always @(negedge clk) begin
        lat[0] <= am[0];
        lat[1] <= am[1];
    end
    always @(posedge clk) begin
        if (ld[0]) rq[0] <= rd[0];
        else if (sh[0]) rq[0] <= 17'($signed(rq[0]) >>> lat[0]);
        if (ld[1]) rq[1] <= rd[1];
        else if (sh[1]) rq[1] <= 17'($signed(rq[1]) >>> lat[1]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Step list from multiplier run lengths, each run split into chunks of at most maxs.
    task automatic model(input int k, input logic [7:0] q, input int maxs);
        int i, run, rem, a;
        logic prev;
        exp_n[k] = 0;
        exp_loads[k] = 1;
        i = 0;
        while (i < 8) begin
            prev = (i == 0) ? 1'b0 : q[i-1];
            if (q[i] != prev) exp_loads[k]++;
            run = 1;
            while (i + run < 8 && q[i+run] == q[i]) run++;
            rem = run;
            while (rem > 0) begin
                a = (rem > maxs) ? maxs : rem;
                exp_amt[k][exp_n[k]] = a;
                exp_n[k]++;
                rem -= a;
            end
            i += run;
        end
    endtask

    function automatic logic [15:0] mul(input logic [7:0] m, input logic [7:0] q);
        int r;
        r = int'($signed(m)) * int'($signed(q));
        return 16'(r);
    endfunction

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_outs%0d", tag, k),
                {5'd0, ld[k], sh[k], bsy[k], dn[k], er[k], am[k], pr[k]}, 32'd0);
    endtask

    task automatic run(input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] p8, input logic e8, input int c8);
        int cyc;
        int done_cyc [2];
        logic [15:0] prod [2];
        logic errv [2];
        int got_n [2];
        int amt_bad [2];
        int loads [2];
        int excl [2];
        int idle_bad [2];
        logic seen [2];
        logic [15:0] exp_p;
        logic exp_e;
        int exp_c;
        model(0, q, 8);
        model(1, q, 4);
        for (int k = 0; k < 2; k++) begin
            done_cyc[k] = -1; prod[k] = '0; errv[k] = 1'b0; got_n[k] = 0;
            amt_bad[k] = 0; loads[k] = 0; excl[k] = 0; idle_bad[k] = 0; seen[k] = 1'b0;
        end
        @(negedge clk);
        multiplicand = m; multiplier = q; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!(seen[0] && seen[1]) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!seen[k]) begin
                    if (ld[k] && sh[k]) excl[k]++;
                    if (ld[k]) loads[k]++;
                    if (sh[k]) begin
                        if (got_n[k] >= 16 || int'(am[k]) != exp_amt[k][got_n[k]]) amt_bad[k]++;
                        got_n[k]++;
                    end
                    if (dn[k]) begin
                        seen[k] = 1'b1; done_cyc[k] = cyc; prod[k] = pr[k]; errv[k] = er[k];
                    end
                end else if (cyc == done_cyc[k] + 1 && bsy[k]) idle_bad[k]++;
            end
            // Noise while both are busy; start is forced high in any done cycle.
            if (bsy[0] && bsy[1]) begin
                start = (dn[0] || dn[1]) ? 1'b1 : 1'($urandom_range(0, 1));
                if (cyc >= 2) begin
                    multiplicand = 8'($urandom);
                    multiplier = 8'($urandom);
                end
            end else start = 1'b0;
        end
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++)
            if (cyc == done_cyc[k] + 1 && bsy[k]) idle_bad[k]++;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_p = (k == 0) ? p8 : mul(m, q);
            exp_e = (k == 0) ? e8 : (m == 8'h80);
            exp_c = (k == 0) ? c8 : 2 * exp_n[1] + 2;
            chk($sformatf("done_cycle%0d m=%h q=%h", k, m, q), done_cyc[k], exp_c);
            chk($sformatf("err%0d m=%h q=%h", k, m, q), {31'd0, errv[k]}, {31'd0, exp_e});
            if (!exp_e) chk($sformatf("product%0d m=%h q=%h", k, m, q), {16'd0, prod[k]}, {16'd0, exp_p});
            chk($sformatf("amount_seq%0d q=%h", k, q), amt_bad[k], 0);
            chk($sformatf("shift_count%0d q=%h", k, q), got_n[k], exp_n[k]);
            chk($sformatf("load_count%0d q=%h", k, q), loads[k], exp_loads[k]);
            chk($sformatf("load_shift_excl%0d", k), excl[k], 0);
            chk($sformatf("idle_after_done%0d", k), idle_bad[k], 0);
        end
    endtask

    initial begin
        logic [7:0] rm, rqv;
        int waitc;
        tbl[0] = '{8'h07, 8'h0F, 16'h0069, 1'b0, 6};
        tbl[1] = '{8'hFD, 8'h05, 16'hFFF1, 1'b0, 10};
        tbl[2] = '{8'h55, 8'h55, 16'h1C39, 1'b0, 18};
        tbl[3] = '{8'h12, 8'h00, 16'h0000, 1'b0, 4};
        tbl[4] = '{8'h80, 8'h01, 16'h0000, 1'b1, 6};
        tbl[5] = '{8'h7F, 8'h80, 16'hC080, 1'b0, 6};

        reset_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run(tbl[t].m, tbl[t].q, tbl[t].prod, tbl[t].err, tbl[t].cyc);

        // Abort mid-shift, then a fresh multiply must reload the register.
        @(negedge clk);
        multiplicand = 8'h07; multiplier = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitc = 0;
        while (!sh[0] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("reached_shift", {31'd0, sh[0]}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        run(8'h02, 8'hFF, 16'hFFFE, 1'b0, 4);

        for (int r = 0; r < 25; r++) begin
            rm = 8'($urandom);
            rqv = 8'($urandom);
            model(0, rqv, 8);
            run(rm, rqv, mul(rm, rqv), rm == 8'h80, 2 * exp_n[0] + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
